issue_warp_scheduler: RTL and testbench
=======================================

// Module: issue_warp_scheduler
// PURPOSE
//  Per-warp issue scheduler between the per-warp instruction buffer heads and the
//  issue/operand-fetch path. Each cycle it picks one warp whose head is valid and
//  scoreboard-clear, round-robin, and registers it into a single output slot.
//  The slot drives the execute dispatch with a valid/ready handshake.
//  It also keeps issue and stall performance counters.
// PARAMETERS
//  NUM_WARPS  4   number of requesting warps (>=1)
//  DATAW      64  width of the per-warp decoded-instruction payload
//  WIDW       `CLOG2 of NUM_WARPS, minimum 1 (derived)  warp-id width
//  PERFW      44  width of the performance counters
// PORTS
//  clk          in   1                clock
//  reset_n      in   1                synchronous reset, active-low
//  req_valid    in   NUM_WARPS        warp w head instruction valid
//  req_data     in   NUM_WARPS*DATAW  payloads; warp w at [w*DATAW +: DATAW]
//  scb_ready    in   NUM_WARPS        warp w operands hazard-free (scoreboard)
//  req_ready    out  NUM_WARPS        one-hot dequeue strobe to warp w
//  issue_valid  out  1                output slot holds an instruction
//  issue_wid    out  WIDW             warp id of the slot
//  issue_data   out  DATAW            payload of the slot
//  issue_ready  in   1                downstream accepts the slot
//  issue_cnt    out  PERFW            count of issue_valid&&issue_ready cycles
//  stall_cnt    out  PERFW            count of cycles with |req_valid but no grant
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): issue_valid=0, issue_wid=0, issue_data=0,
//    counters=0, rr pointer last=NUM_WARPS-1 (warp 0 wins first). req_ready is
//    combinational and is 0 while reset_n==0. Any slot content is dropped.
//  - eligible = req_valid & scb_ready. load_en = !issue_valid || issue_ready.
//  - Grant: if load_en && |eligible, pick the first eligible warp scanning
//    last+1, last+2, ... modulo NUM_WARPS. req_ready = onehot(grant) in the
//    same cycle; all other bits are 0. req_ready is never asserted without
//    load_en.
//  - On a grant at posedge: slot <= {1, grant, req_data[grant]}; last <= grant.
//    Latency from warp dequeue to issue_valid is 1 cycle.
//  - No grant and issue_ready: issue_valid <= 0. No grant and !issue_ready:
//    the slot holds.
//  - Backpressure: while issue_valid && !issue_ready, issue_wid and issue_data
//    stay stable, req_ready is 0, and last does not change.
//  - Simultaneous accept and new grant in the same cycle: back-to-back issue,
//    with no bubble.
//  - scb_ready drop: a warp with req_valid=1 and scb_ready=0 is skipped. It
//    keeps its round-robin position relative to last.
//  - NUM_WARPS==1: the rr pointer is constant. Grant = eligible[0] && load_en.
//  - Counters increment by 1 and wrap modulo 2^PERFW.
//    stall_cnt condition: |req_valid && no grant. This covers scoreboard and
//    backpressure stalls.
//  - Assertions: req_ready is one-hot or zero. issue_data must not change
//    while issue_valid && !issue_ready.
// TESTING
//  1. Reset with all warps eligible, issue_ready=1 -> grants w0,w1,w2,w3,w0 on
//     consecutive cycles. issue_valid rises 1 cycle after reset_n=1.
//     issue_cnt=4 after 5 cycles.
//  2. Only w2 eligible, data 0xABCD -> req_ready=4'b0100. The next cycle shows
//     issue_wid=2, issue_data=0xABCD.
//  3. Slot full, issue_ready=0 for 3 cycles, w1 waiting -> req_ready=0, slot
//     stable, stall_cnt+=3. When issue_ready=1, w1 is granted that same cycle.
//  4. w0,w1 valid, scb_ready=2'b01 -> only w0 is granted, repeatedly.
//     scb_ready=2'b11 then grants w1 next, because w1 follows last=0.
//  5. reset_n=0 while the slot is full and stalled -> next cycle issue_valid=0,
//     counters=0. After release, w0 has priority.
//  6. Counters preloaded to 2^44-1 (force) then one issue -> issue_cnt wraps
//     to 0.

Source files
------------

// File: rtl/issue_warp_scheduler.sv
// Per-warp issue scheduler: round-robin pick among valid, scoreboard-clear warp heads,
// registered into a single valid/ready output slot, plus issue/stall perf counters.
module issue_warp_scheduler #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned DATAW     = 64,
  parameter int unsigned WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int unsigned PERFW     = 44
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_WARPS-1:0]       req_valid,
  input  logic [NUM_WARPS*DATAW-1:0] req_data,
  input  logic [NUM_WARPS-1:0]       scb_ready,
  output logic [NUM_WARPS-1:0]       req_ready,
  output logic                       issue_valid,
  output logic [WIDW-1:0]            issue_wid,
  output logic [DATAW-1:0]           issue_data,
  input  logic                       issue_ready,
  output logic [PERFW-1:0]           issue_cnt,
  output logic [PERFW-1:0]           stall_cnt
);

  logic [NUM_WARPS-1:0]       eligible;
  logic                       load_en;
  logic                       grant_valid;
  logic                       grant_found;
  logic [WIDW-1:0]            grant_idx;
  int unsigned                grant_int;
  int unsigned                scan_idx;
  logic [NUM_WARPS-1:0]       scan_rot;
  logic [NUM_WARPS-1:0]       grant_onehot;
  logic [NUM_WARPS*DATAW-1:0] data_shift;
  logic [DATAW-1:0]           grant_data;

  logic                       issue_valid_q, issue_valid_d;
  logic [WIDW-1:0]            issue_wid_q, issue_wid_d;
  logic [DATAW-1:0]           issue_data_q, issue_data_d;
  logic [WIDW-1:0]            last_q, last_d;
  logic [PERFW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [PERFW-1:0]           stall_cnt_q, stall_cnt_d;

  assign eligible = req_valid & scb_ready;
  assign load_en  = !issue_valid_q || issue_ready;

  // Round-robin scan starting just after the last granted warp.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    scan_rot    = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      scan_idx = (32'(last_q) + i) % NUM_WARPS;
      scan_rot = eligible >> scan_idx;
      if (!grant_found && scan_rot[0]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[WIDW-1:0];
      end
    end
  end

  // Grant decode, payload select and dequeue strobe.
  always_comb begin
    grant_valid  = load_en && grant_found;
    grant_int    = 32'(grant_idx);
    data_shift   = req_data >> (DATAW * grant_int);
    grant_data   = data_shift[DATAW-1:0];
    grant_onehot = grant_valid ? (NUM_WARPS'(1) << grant_int) : '0;
    // Strobe is suppressed during reset so no warp dequeues into a dropped slot.
    req_ready    = reset_n ? grant_onehot : '0;
  end

  // Next-state for the output slot, rr pointer and perf counters.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_wid_d   = issue_wid_q;
    issue_data_d  = issue_data_q;
    last_d        = last_q;
    issue_cnt_d   = issue_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (grant_valid) begin
      issue_valid_d = 1'b1;
      issue_wid_d   = grant_idx;
      issue_data_d  = grant_data;
      last_d        = grant_idx;
    end else if (issue_ready) begin
      issue_valid_d = 1'b0;
    end
    if (issue_valid_q && issue_ready) begin
      issue_cnt_d = issue_cnt_q + PERFW'(1);
    end
    if (|req_valid && !grant_valid) begin
      stall_cnt_d = stall_cnt_q + PERFW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      issue_data_q  <= '0;
      last_q        <= WIDW'(NUM_WARPS - 1);
      issue_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_wid_q   <= issue_wid_d;
      issue_data_q  <= issue_data_d;
      last_q        <= last_d;
      issue_cnt_q   <= issue_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_wid   = issue_wid_q;
  assign issue_data  = issue_data_q;
  assign issue_cnt   = issue_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  logic             hold_q;
  logic [DATAW-1:0] data_prev_q;

  // Remember whether the slot was stalled at the previous edge, for the stability check.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= issue_valid_q && !issue_ready;
    end
    data_prev_q <= issue_data_q;
  end

  // Protocol checks: one-hot dequeue and stable payload under backpressure.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert ($onehot0(req_ready))
        else $error("req_ready not one-hot: %b", req_ready);
      if (hold_q) begin
        assert (issue_data_q == data_prev_q)
          else $error("issue_data changed while stalled");
      end
    end
  end

endmodule

// File: tb/tb_issue_warp_scheduler.sv
// Directed bench for issue_warp_scheduler: round-robin order, single-warp grant,
// backpressure, scoreboard skipping, reset mid-stall and counter wrap.
module tb_issue_warp_scheduler;

  localparam int NW = 4;
  localparam int DW = 64;
  localparam int WW = 2;
  localparam int PW = 44;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NW-1:0]    req_valid;
  logic [NW*DW-1:0] req_data;
  logic [NW-1:0]    scb_ready;
  logic [NW-1:0]    req_ready;
  logic             issue_valid;
  logic [WW-1:0]    issue_wid;
  logic [DW-1:0]    issue_data;
  logic             issue_ready;
  logic [PW-1:0]    issue_cnt;
  logic [PW-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_warp_scheduler #(
    .NUM_WARPS(NW),
    .DATAW    (DW),
    .WIDW     (WW),
    .PERFW    (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .scb_ready  (scb_ready),
    .req_ready  (req_ready),
    .issue_valid(issue_valid),
    .issue_wid  (issue_wid),
    .issue_data (issue_data),
    .issue_ready(issue_ready),
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the active edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 4'hF;
    scb_ready   = 4'hF;
    issue_ready = 1'b1;
    for (int w = 0; w < NW; w++) req_data[w*DW +: DW] = 64'h1000 + 64'(w);

    // Reset: outputs cleared, no dequeue strobe while reset is low.
    tick();
    mid();
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_valid", 64'(issue_valid), 64'h0);
    chk("reset_wid", 64'(issue_wid), 64'h0);
    chk("reset_data", issue_data, 64'h0);
    chk("reset_issue_cnt", 64'(issue_cnt), 64'h0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'h0);
    tick();
    reset_n = 1'b1;

    // 1. All eligible: w0,w1,w2,w3,w0 granted back to back.
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("rr_grant", 64'(req_ready), 64'(1) << (k % 4));
      if (k == 0) begin
        chk("rr_first_valid", 64'(issue_valid), 64'h0);
      end else begin
        chk("rr_valid", 64'(issue_valid), 64'h1);
        chk("rr_wid", 64'(issue_wid), 64'(k - 1));
        chk("rr_data", issue_data, 64'h1000 + 64'(k - 1));
      end
      tick();
    end

    // 2. Only w2 eligible with a distinct payload.
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 64'hABCD;
    mid();
    chk("t1_issue_cnt", 64'(issue_cnt), 64'd4);
    chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("t1_last_wid", 64'(issue_wid), 64'd0);
    chk("w2_req_ready", 64'(req_ready), 64'b0100);
    tick();

    // 3. Backpressure for 3 cycles while w1 waits.
    issue_ready = 1'b0;
    req_valid   = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_valid", 64'(issue_valid), 64'h1);
      chk("bp_wid", 64'(issue_wid), 64'd2);
      chk("bp_data", issue_data, 64'hABCD);
      tick();
    end
    issue_ready = 1'b1;
    mid();
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("bp_issue_cnt", 64'(issue_cnt), 64'd5);
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    tick();

    // 4. w0,w1 valid but only w0 scoreboard-clear.
    req_valid = 4'b0011;
    scb_ready = 4'b0001;
    mid();
    chk("w1_slot_wid", 64'(issue_wid), 64'd1);
    chk("w1_slot_data", issue_data, 64'h1001);
    chk("scb_grant0_a", 64'(req_ready), 64'b0001);
    tick();
    mid();
    chk("scb_slot_wid", 64'(issue_wid), 64'd0);
    chk("scb_grant0_b", 64'(req_ready), 64'b0001);
    tick();
    scb_ready = 4'b0011;
    mid();
    chk("scb_grant1", 64'(req_ready), 64'b0010);
    chk("scb_issue_cnt", 64'(issue_cnt), 64'd8);
    tick();

    // 5. Reset while the slot is full and stalled.
    issue_ready = 1'b0;
    mid();
    chk("pre_rst_wid", 64'(issue_wid), 64'd1);
    chk("pre_rst_req_ready", 64'(req_ready), 64'h0);
    tick();
    reset_n = 1'b0;
    mid();
    chk("stall_before_rst", 64'(stall_cnt), 64'd4);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    tick();
    reset_n = 1'b1;
    mid();
    chk("rst_valid", 64'(issue_valid), 64'h0);
    chk("rst_issue_cnt", 64'(issue_cnt), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_w0_priority", 64'(req_ready), 64'b0001);
    tick();

    // 6. Preload issue counter to all-ones and issue once: wraps to 0.
    req_valid   = 4'b0000;
    issue_ready = 1'b1;
    force dut.issue_cnt_q = {PW{1'b1}};
    #1;
    release dut.issue_cnt_q;
    mid();
    chk("wrap_slot_valid", 64'(issue_valid), 64'h1);
    chk("wrap_slot_wid", 64'(issue_wid), 64'd0);
    tick();
    mid();
    chk("wrap_issue_cnt", 64'(issue_cnt), 64'h0);
    chk("wrap_valid_drop", 64'(issue_valid), 64'h0);
    chk("wrap_stall_cnt", 64'(stall_cnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
